picobello_tile_link_isolate: RTL and testbench

Per-tile NoC link isolation unit for picobello mesh tiles. It sits between a tile's router mesh ports (North..West) and the neighbouring tiles' links. When isolation is requested for a port, the unit drains all three physical channels (req, rsp, wide) in both directions at packet boundaries, then clamps them. The port can then be power-gated or reset independently without corrupting wormhole packets. When the port is active, the unit is a zero-latency pass-through.

---
 rtl/floo_picobello_noc_pkg.sv | 43 ++++
 rtl/picobello_pkg.sv | 15 +
 rtl/picobello_link_gate_chan.sv | 58 +++++
 rtl/picobello_tile_link_isolate.sv | 156 +++++++++++++++
 tb/tb_picobello_tile_link_isolate.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/floo_picobello_noc_pkg.sv
// Link types for picobello mesh links.
// Each link struct carries a valid/flit pair for one direction and the
// ready for the opposite direction. The flit header carries `last`.
package floo_picobello_noc_pkg;

  localparam int unsigned ReqDataW  = 16;
  localparam int unsigned RspDataW  = 16;
  localparam int unsigned WideDataW = 64;

  typedef struct packed {
    logic                 last;
    logic [ReqDataW-1:0]  data;
  } floo_req_flit_t;

  typedef struct packed {
    logic                 last;
    logic [RspDataW-1:0]  data;
  } floo_rsp_flit_t;

  typedef struct packed {
    logic                 last;
    logic [WideDataW-1:0] data;
  } floo_wide_flit_t;

  typedef struct packed {
    logic           valid;
    logic           ready;
    floo_req_flit_t flit;
  } floo_req_t;

  typedef struct packed {
    logic           valid;
    logic           ready;
    floo_rsp_flit_t flit;
  } floo_rsp_t;

  typedef struct packed {
    logic            valid;
    logic            ready;
    floo_wide_flit_t flit;
  } floo_wide_t;

endpackage

// File: rtl/picobello_pkg.sv
// Shared constants and FSM state type for the tile link isolation unit.
package picobello_pkg;

  localparam int unsigned TimeoutCyclesDefault = 1024;

  // Gated streams per port: {req,rsp,wide} x {tile->link, link->tile}
  localparam int unsigned NumStreams = 6;

  typedef enum logic [1:0] {
    IsoActive   = 2'd0,
    IsoDrain    = 2'd1,
    IsoIsolated = 2'd2
  } iso_state_e;

endpackage

// File: rtl/picobello_link_gate_chan.sv
// One channel in one direction of one port: tracks whether a wormhole
// packet is open and masks valid/ready when gated.
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   snd_i        : sender-side link struct (valid + flit used)
//   ready_i      : receiver ready
//   gate_i       : force valid/ready low
//   clr_i        : drop packet tracking (forced isolation)
//   snd_o        : sender struct toward receiver with gated valid
//   ready_o      : gated ready toward sender
//   in_pkt_o     : a packet head was accepted and its tail not yet
module picobello_link_gate_chan #(
  parameter type link_t = floo_picobello_noc_pkg::floo_req_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  link_t snd_i,
  input  logic  ready_i,
  input  logic  gate_i,
  input  logic  clr_i,
  output link_t snd_o,
  output logic  ready_o,
  output logic  in_pkt_o
);

  logic in_pkt_q, in_pkt_d;
  logic hs;

  // Payload passes unmodified; only the handshake is masked.
  always_comb begin
    snd_o       = snd_i;
    snd_o.valid = snd_i.valid & ~gate_i;
  end

  assign ready_o = ready_i & ~gate_i;
  assign hs      = snd_i.valid & ready_i & ~gate_i;

  // Open on a non-tail handshake, close on a tail handshake.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (clr_i) begin
      in_pkt_d = 1'b0;
    end else if (hs) begin
      in_pkt_d = ~snd_i.flit.last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt_o = in_pkt_q;

endmodule

// File: rtl/picobello_tile_link_isolate.sv
// Per-tile NoC link isolation: drains req/rsp/wide in both directions at
// packet boundaries, then clamps the port so it can be gated or reset.
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   isolate_req_i         : per-port isolation request (level)
//   isolated_o            : per-port isolation acknowledge
//   timeout_o             : per-port, last isolation was forced by timeout
//   tile_*_i / tile_*_o   : router side
//   link_*_i / link_*_o   : neighbour side
module picobello_tile_link_isolate
  import picobello_pkg::*;
#(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault,
  parameter type floo_req_t  = floo_picobello_noc_pkg::floo_req_t,
  parameter type floo_rsp_t  = floo_picobello_noc_pkg::floo_rsp_t,
  parameter type floo_wide_t = floo_picobello_noc_pkg::floo_wide_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] isolate_req_i,
  output logic [NumPorts-1:0] isolated_o,
  output logic [NumPorts-1:0] timeout_o,
  input  floo_req_t           tile_req_i  [NumPorts],
  input  floo_rsp_t           tile_rsp_i  [NumPorts],
  input  floo_wide_t          tile_wide_i [NumPorts],
  output floo_req_t           tile_req_o  [NumPorts],
  output floo_rsp_t           tile_rsp_o  [NumPorts],
  output floo_wide_t          tile_wide_o [NumPorts],
  input  floo_req_t           link_req_i  [NumPorts],
  input  floo_rsp_t           link_rsp_i  [NumPorts],
  input  floo_wide_t          link_wide_i [NumPorts],
  output floo_req_t           link_req_o  [NumPorts],
  output floo_rsp_t           link_rsp_o  [NumPorts],
  output floo_wide_t          link_wide_o [NumPorts]
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax      = '1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic            TimeoutEn   = (TimeoutCycles != 0);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    iso_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  isolated_q, isolated_d;
    logic                  timeout_q, timeout_d;
    logic                  clr_c;
    logic [NumStreams-1:0] in_pkt, gate, rdy;
    floo_req_t             req_out, req_in, lreq, treq;
    floo_rsp_t             rsp_out, rsp_in, lrsp, trsp;
    floo_wide_t            wide_out, wide_in, lwide, twide;

    // A stream stays open while it carries an unfinished packet.
    assign gate = (state_q == IsoActive) ? '0 : ~in_pkt;

    // Stream index: even = tile->link, odd = link->tile.
    picobello_link_gate_chan #(.link_t(floo_req_t)) i_req_out (
      .clk_i, .rst_i, .snd_i(tile_req_i[p]), .ready_i(link_req_i[p].ready),
      .gate_i(gate[0]), .clr_i(clr_c), .snd_o(req_out), .ready_o(rdy[0]), .in_pkt_o(in_pkt[0]));
    picobello_link_gate_chan #(.link_t(floo_req_t)) i_req_in (
      .clk_i, .rst_i, .snd_i(link_req_i[p]), .ready_i(tile_req_i[p].ready),
      .gate_i(gate[1]), .clr_i(clr_c), .snd_o(req_in), .ready_o(rdy[1]), .in_pkt_o(in_pkt[1]));
    picobello_link_gate_chan #(.link_t(floo_rsp_t)) i_rsp_out (
      .clk_i, .rst_i, .snd_i(tile_rsp_i[p]), .ready_i(link_rsp_i[p].ready),
      .gate_i(gate[2]), .clr_i(clr_c), .snd_o(rsp_out), .ready_o(rdy[2]), .in_pkt_o(in_pkt[2]));
    picobello_link_gate_chan #(.link_t(floo_rsp_t)) i_rsp_in (
      .clk_i, .rst_i, .snd_i(link_rsp_i[p]), .ready_i(tile_rsp_i[p].ready),
      .gate_i(gate[3]), .clr_i(clr_c), .snd_o(rsp_in), .ready_o(rdy[3]), .in_pkt_o(in_pkt[3]));
    picobello_link_gate_chan #(.link_t(floo_wide_t)) i_wide_out (
      .clk_i, .rst_i, .snd_i(tile_wide_i[p]), .ready_i(link_wide_i[p].ready),
      .gate_i(gate[4]), .clr_i(clr_c), .snd_o(wide_out), .ready_o(rdy[4]), .in_pkt_o(in_pkt[4]));
    picobello_link_gate_chan #(.link_t(floo_wide_t)) i_wide_in (
      .clk_i, .rst_i, .snd_i(link_wide_i[p]), .ready_i(tile_wide_i[p].ready),
      .gate_i(gate[5]), .clr_i(clr_c), .snd_o(wide_in), .ready_o(rdy[5]), .in_pkt_o(in_pkt[5]));

    // Each outgoing struct pairs one direction's valid/flit with the
    // opposite direction's ready.
    always_comb begin
      lreq        = req_out;
      lreq.ready  = rdy[1];
      treq        = req_in;
      treq.ready  = rdy[0];
      lrsp        = rsp_out;
      lrsp.ready  = rdy[3];
      trsp        = rsp_in;
      trsp.ready  = rdy[2];
      lwide       = wide_out;
      lwide.ready = rdy[5];
      twide       = wide_in;
      twide.ready = rdy[4];
    end

    assign link_req_o[p]  = lreq;
    assign tile_req_o[p]  = treq;
    assign link_rsp_o[p]  = lrsp;
    assign tile_rsp_o[p]  = trsp;
    assign link_wide_o[p] = lwide;
    assign tile_wide_o[p] = twide;

    // Isolation FSM and drain timeout counter.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      clr_c     = 1'b0;
      unique case (state_q)
        IsoActive: begin
          if (isolate_req_i[p]) begin
            state_d = IsoDrain;
            cnt_d   = '0;
          end
        end
        IsoDrain: begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          if (!isolate_req_i[p]) begin
            state_d = IsoActive;
          end else if (in_pkt == '0) begin
            state_d = IsoIsolated;
          end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
            // Abandon stuck packets; neighbours are reset together.
            state_d   = IsoIsolated;
            timeout_d = 1'b1;
            clr_c     = 1'b1;
          end
        end
        IsoIsolated: begin
          if (!isolate_req_i[p]) begin
            state_d   = IsoActive;
            timeout_d = 1'b0;
          end
        end
        default: state_d = IsoActive;
      endcase
      isolated_d = (state_d == IsoIsolated);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q    <= IsoActive;
        cnt_q      <= '0;
        isolated_q <= 1'b0;
        timeout_q  <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        isolated_q <= isolated_d;
        timeout_q  <= timeout_d;
      end
    end

    assign isolated_o[p] = isolated_q;
    assign timeout_o[p]  = timeout_q;
  end

endmodule

// File: tb/tb_picobello_tile_link_isolate.sv
// Directed bench for picobello_tile_link_isolate (port 0 wide channel plus
// port 3 req channel as a bystander), TimeoutCycles = 16.
module tb_picobello_tile_link_isolate;
  import floo_picobello_noc_pkg::*;

  localparam int unsigned NP = 4;
  localparam int unsigned TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NP-1:0] isolate_req_i;
  logic [NP-1:0] isolated_o, timeout_o;
  floo_req_t     tile_req_i [NP], tile_req_o [NP], link_req_i [NP], link_req_o [NP];
  floo_rsp_t     tile_rsp_i [NP], tile_rsp_o [NP], link_rsp_i [NP], link_rsp_o [NP];
  floo_wide_t    tile_wide_i[NP], tile_wide_o[NP], link_wide_i[NP], link_wide_o[NP];

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  picobello_tile_link_isolate #(.NumPorts(NP), .TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .isolate_req_i(isolate_req_i), .isolated_o(isolated_o), .timeout_o(timeout_o),
    .tile_req_i(tile_req_i), .tile_rsp_i(tile_rsp_i), .tile_wide_i(tile_wide_i),
    .tile_req_o(tile_req_o), .tile_rsp_o(tile_rsp_o), .tile_wide_o(tile_wide_o),
    .link_req_i(link_req_i), .link_rsp_i(link_rsp_i), .link_wide_i(link_wide_i),
    .link_req_o(link_req_o), .link_rsp_o(link_rsp_o), .link_wide_o(link_wide_o)
  );

  typedef struct {
    logic [3:0] iso;
    logic       tw_v, tw_l, lw_r, lw_v, lw_l, tw_r;
    logic [3:0] e_iso, e_to;
    logic       e_lwo_v, e_two_r, e_two_v, e_lwo_r, e_p3_v;
  } vec_t;

  vec_t vq[$];

  // in_b = {tw_v,tw_l,lw_r, lw_v,lw_l,tw_r}; e_b = {lwo_v,two_r,two_v,lwo_r,p3_v}
  function automatic vec_t mk(logic [3:0] iso, logic [5:0] in_b,
                              logic [3:0] e_iso, logic [3:0] e_to, logic [4:0] e_b);
    vec_t v;
    v.iso = iso;
    {v.tw_v, v.tw_l, v.lw_r, v.lw_v, v.lw_l, v.tw_r} = in_b;
    v.e_iso = e_iso;
    v.e_to  = e_to;
    {v.e_lwo_v, v.e_two_r, v.e_two_v, v.e_lwo_r, v.e_p3_v} = e_b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_defaults();
    for (int p = 0; p < NP; p++) begin
      tile_req_i[p]  = '0; tile_req_i[p].ready  = 1'b1;
      tile_rsp_i[p]  = '0; tile_rsp_i[p].ready  = 1'b1;
      tile_wide_i[p] = '0; tile_wide_i[p].ready = 1'b1;
      link_req_i[p]  = '0; link_req_i[p].ready  = 1'b1;
      link_rsp_i[p]  = '0; link_rsp_i[p].ready  = 1'b1;
      link_wide_i[p] = '0; link_wide_i[p].ready = 1'b1;
    end
    // Port 3 streams single-flit req packets every cycle.
    tile_req_i[3].valid     = 1'b1;
    tile_req_i[3].flit.last = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // idle/release on idle port
    vq.push_back(mk(4'h0, 6'b111_111, 4'h0, 4'h0, 5'b11111));
    vq.push_back(mk(4'h1, 6'b001_001, 4'h0, 4'h0, 5'b01011));
    vq.push_back(mk(4'h1, 6'b111_001, 4'h0, 4'h0, 5'b00001));
    vq.push_back(mk(4'h1, 6'b101_001, 4'h1, 4'h0, 5'b00001));
    vq.push_back(mk(4'h0, 6'b111_001, 4'h1, 4'h0, 5'b00001));
    vq.push_back(mk(4'h0, 6'b111_001, 4'h0, 4'h0, 5'b11011));
    // 4-flit packet drained across isolation
    vq.push_back(mk(4'h0, 6'b101_001, 4'h0, 4'h0, 5'b11011));
    vq.push_back(mk(4'h1, 6'b101_001, 4'h0, 4'h0, 5'b11011));
    vq.push_back(mk(4'h1, 6'b101_001, 4'h0, 4'h0, 5'b11001));
    vq.push_back(mk(4'h1, 6'b110_001, 4'h0, 4'h0, 5'b10001));
    vq.push_back(mk(4'h1, 6'b111_001, 4'h0, 4'h0, 5'b11001));
    vq.push_back(mk(4'h1, 6'b101_001, 4'h0, 4'h0, 5'b00001));
    vq.push_back(mk(4'h1, 6'b101_001, 4'h1, 4'h0, 5'b00001));
    vq.push_back(mk(4'h0, 6'b001_001, 4'h1, 4'h0, 5'b00001));
    vq.push_back(mk(4'h0, 6'b001_001, 4'h0, 4'h0, 5'b01011));
    // stalled packet, forced isolation after 16 DRAIN cycles
    vq.push_back(mk(4'h0, 6'b101_001, 4'h0, 4'h0, 5'b11011));
    vq.push_back(mk(4'h1, 6'b001_001, 4'h0, 4'h0, 5'b01011));
    for (int k = 0; k < int'(TO); k++)
      vq.push_back(mk(4'h1, 6'b001_001, 4'h0, 4'h0, 5'b01001));
    vq.push_back(mk(4'h1, 6'b001_001, 4'h1, 4'h1, 5'b00001));
    vq.push_back(mk(4'h0, 6'b001_001, 4'h1, 4'h1, 5'b00001));
    vq.push_back(mk(4'h0, 6'b111_001, 4'h0, 4'h0, 5'b11011));
    // DRAIN aborted mid-packet on the inbound stream
    vq.push_back(mk(4'h0, 6'b001_101, 4'h0, 4'h0, 5'b01111));
    vq.push_back(mk(4'h1, 6'b001_101, 4'h0, 4'h0, 5'b01111));
    vq.push_back(mk(4'h1, 6'b001_101, 4'h0, 4'h0, 5'b00111));
    vq.push_back(mk(4'h0, 6'b001_101, 4'h0, 4'h0, 5'b00111));
    vq.push_back(mk(4'h0, 6'b001_111, 4'h0, 4'h0, 5'b01111));
    vq.push_back(mk(4'h0, 6'b001_001, 4'h0, 4'h0, 5'b01011));
    // all ports at once
    vq.push_back(mk(4'hF, 6'b001_001, 4'h0, 4'h0, 5'b01011));
    vq.push_back(mk(4'hF, 6'b001_001, 4'h0, 4'h0, 5'b00000));
    vq.push_back(mk(4'hF, 6'b001_001, 4'hF, 4'h0, 5'b00000));
    vq.push_back(mk(4'h0, 6'b001_001, 4'hF, 4'h0, 5'b00000));
    vq.push_back(mk(4'h0, 6'b001_001, 4'h0, 4'h0, 5'b01011));

    // Reset state and pass-through while held in reset.
    rst_i         = 1'b1;
    isolate_req_i = '0;
    drive_defaults();
    tile_wide_i[0].valid = 1'b1;
    #1;
    chk("reset_isolated", 64'(isolated_o), 64'h0);
    chk("reset_timeout", 64'(timeout_o), 64'h0);
    chk("reset_pass_valid", 64'(link_wide_o[0].valid), 64'h1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vq[i]) begin
      vec_t v;
      logic [63:0] d_out, d_in;
      v     = vq[i];
      d_out = 64'(i * 3 + 1);
      d_in  = 64'(i * 7 + 5);
      @(negedge clk_i);
      isolate_req_i                 = v.iso;
      tile_wide_i[0].valid          = v.tw_v;
      tile_wide_i[0].flit.last      = v.tw_l;
      tile_wide_i[0].flit.data      = d_out;
      tile_wide_i[0].ready          = v.tw_r;
      link_wide_i[0].valid          = v.lw_v;
      link_wide_i[0].flit.last      = v.lw_l;
      link_wide_i[0].flit.data      = d_in;
      link_wide_i[0].ready          = v.lw_r;
      #1;
      chk($sformatf("v%0d_isolated", i), 64'(isolated_o), 64'(v.e_iso));
      chk($sformatf("v%0d_timeout", i), 64'(timeout_o), 64'(v.e_to));
      chk($sformatf("v%0d_link_valid", i), 64'(link_wide_o[0].valid), 64'(v.e_lwo_v));
      chk($sformatf("v%0d_tile_ready", i), 64'(tile_wide_o[0].ready), 64'(v.e_two_r));
      chk($sformatf("v%0d_tile_valid", i), 64'(tile_wide_o[0].valid), 64'(v.e_two_v));
      chk($sformatf("v%0d_link_ready", i), 64'(link_wide_o[0].ready), 64'(v.e_lwo_r));
      chk($sformatf("v%0d_p3_req_valid", i), 64'(link_req_o[3].valid), 64'(v.e_p3_v));
      chk($sformatf("v%0d_out_data", i), link_wide_o[0].flit.data, d_out);
      chk($sformatf("v%0d_in_data", i), tile_wide_o[0].flit.data, d_in);
    end

    // Reset pulse during DRAIN with an open outbound packet.
    @(negedge clk_i);
    isolate_req_i            = '0;
    drive_defaults();
    tile_wide_i[0].valid     = 1'b1;
    tile_wide_i[0].flit.last = 1'b0;
    @(negedge clk_i);
    isolate_req_i[0]         = 1'b1;
    tile_wide_i[0].valid     = 1'b0;
    @(negedge clk_i);
    #1;
    chk("rst_pre_link_ready", 64'(link_wide_o[0].ready), 64'h0);
    chk("rst_pre_tile_ready", 64'(tile_wide_o[0].ready), 64'h1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_isolated", 64'(isolated_o), 64'h0);
    chk("rst_mid_timeout", 64'(timeout_o), 64'h0);
    chk("rst_mid_link_ready", 64'(link_wide_o[0].ready), 64'h1);
    isolate_req_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    isolate_req_i[0] = 1'b1;
    @(negedge clk_i);
    #1;
    chk("rst_post_drain_isolated", 64'(isolated_o), 64'h0);
    @(negedge clk_i);
    #1;
    chk("rst_post_isolated", 64'(isolated_o), 64'h1);
    chk("rst_post_timeout", 64'(timeout_o), 64'h0);
    isolate_req_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_post_release", 64'(isolated_o), 64'h0);
    chk("rst_post_pass_ready", 64'(tile_wide_o[0].ready), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
